// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
//   Shared types and helpers for the CORDIC front end.
//   - cordic_mode_e  : rotation / vectoring selector
//   - quadrant_t     : 2-bit original quadrant of a rotation request
//   - cordic_entry_t : one transformed request as buffered ahead of stage 0
//   - x_init()       : rotation start vector length, with or without gain
//                      pre-compensation
//   - sat_negate()   : two's-complement negate that clamps -2^(BW-1)
// Configuration macro: CORDIC_GAIN_COMP_EN
//   defined   -> x_init() returns round((2^(bw-1)-1) * 0.607252935)
//   undefined -> x_init() returns 2^(bw-1)-1 (gain is corrected downstream)
// -----------------------------------------------------------------------------
package cordic_pkg;

  // Datapath width of the pipeline; the front end's BIT_WIDTH must equal it.
  localparam int CORDIC_BW = 16;

  typedef enum logic {
    MODE_ROTATION  = 1'b0,
    MODE_VECTORING = 1'b1
  } cordic_mode_e;

  typedef logic [1:0] quadrant_t;

  typedef struct packed {
    logic        [CORDIC_BW-1:0] target;
    logic signed [CORDIC_BW-1:0] x;
    logic signed [CORDIC_BW-1:0] y;
    cordic_mode_e                mode;
    quadrant_t                   quadrant;
    logic                        fold;
  } cordic_entry_t;

  // Elaboration-time constant; integer arithmetic keeps it synthesizable.
  function automatic logic signed [CORDIC_BW-1:0] x_init(input int unsigned bw);
    longint full;
    full = (longint'(1) << (bw - 1)) - 1;
`ifdef CORDIC_GAIN_COMP_EN
    // Scale by the inverse CORDIC gain 0.607252935, rounded to nearest.
    full = (full * 607252935 + 500000000) / 1000000000;
`endif
    return full[CORDIC_BW-1:0];
  endfunction

  // -2^(BW-1) has no positive counterpart; clamp it to the largest positive.
  function automatic logic signed [CORDIC_BW-1:0] sat_negate(
    input logic signed [CORDIC_BW-1:0] v
  );
    logic signed [CORDIC_BW-1:0] min_v;
    min_v = {1'b1, {(CORDIC_BW-1){1'b0}}};
    if (v == min_v) return ~min_v;
    return -v;
  endfunction

endpackage

// File: rtl/cordic_skid_fifo.sv
// -----------------------------------------------------------------------------
// cordic_skid_fifo
//   Generic 2-entry FIFO with a registered ready flag.
//   Ports:
//     clk      in   clock, rising edge
//     reset    in   asynchronous, active-high reset
//     i_push   in   write request (accepted only when o_ready = 1)
//     i_din    in   entry to write at the tail
//     o_ready  out  registered (count < 2)
//     i_pop    in   retire request (ignored when empty)
//     o_head   out  head entry; all zeros while empty
//     o_count  out  number of stored entries, 0..2
// -----------------------------------------------------------------------------
module cordic_skid_fifo #(
  parameter type T = logic
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  T           i_din,
  output logic       o_ready,
  input  logic       i_pop,
  output T           o_head,
  output logic [1:0] o_count
);

  T           r_mem [0:1];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       r_ready;

  logic       w_push;
  logic       w_pop;
  logic [1:0] w_count_next;

  assign w_push = i_push & r_ready;
  assign w_pop  = i_pop & (r_count != 2'd0);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the two storage entries are reset because a discarded request must never reappear.
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_count_next;
      // Ready comes from the next-state count: no in_valid -> ready path.
      r_ready <= (w_count_next != 2'd2);
    end
  end

  assign o_ready = r_ready;
  assign o_count = r_count;
  assign o_head  = (r_count == 2'd0) ? T'('0) : r_mem[r_rd_ptr];

endmodule

// File: rtl/cordic_input_stage.sv
// -----------------------------------------------------------------------------
// cordic_input_stage
//   Front end of the pipelined CORDIC core. Transforms each request (rotation:
//   quadrant reduction; vectoring: fold into the right half-plane), buffers it
//   in a 2-entry skid FIFO and presents the head entry to stage 0.
//   Ports:
//     clk, reset (async, active-high)
//     start              pipeline advance; pops the head when out_done = 1
//     in_valid/in_ready  request handshake (in_ready registered)
//     in_mode            0 rotation, 1 vectoring
//     in_angle           [BW+1:BW] quadrant, [BW-1:0] residual
//     in_x, in_y         signed vectoring operands
//     out_target_angle, out_current_angle, out_x, out_y, out_mode, out_done
//                        stage-0 initial values of the head entry
//     out_quadrant, out_fold   side tag for the back end
// Configuration macro: CORDIC_GAIN_COMP_EN (selects the rotation X_INIT, see
//   cordic_pkg::x_init).
// -----------------------------------------------------------------------------
module cordic_input_stage
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_mode,
  input  logic        [BIT_WIDTH+1:0] in_angle,
  input  logic signed [BIT_WIDTH-1:0] in_x,
  input  logic signed [BIT_WIDTH-1:0] in_y,
  output logic        [BIT_WIDTH-1:0] out_target_angle,
  output logic signed [BIT_WIDTH:0]   out_current_angle,
  output logic signed [BIT_WIDTH-1:0] out_x,
  output logic signed [BIT_WIDTH-1:0] out_y,
  output logic                        out_mode,
  output logic                        out_done,
  output logic        [1:0]           out_quadrant,
  output logic                        out_fold
);

  localparam logic signed [BIT_WIDTH-1:0] X_INIT = x_init(BIT_WIDTH);

  quadrant_t              w_quadrant;
  logic [BIT_WIDTH-1:0]   w_residual;
  cordic_entry_t          w_entry;
  cordic_entry_t          w_head;
  logic [1:0]             w_count;

  assign w_quadrant = in_angle[BIT_WIDTH+1:BIT_WIDTH];
  assign w_residual = in_angle[BIT_WIDTH-1:0];

  always_comb begin
    w_entry      = '0;
    w_entry.mode = cordic_mode_e'(in_mode);
    if (w_entry.mode == MODE_ROTATION) begin
      // Odd quadrants mirror the residual so the core only sees [0, pi/2).
      w_entry.target   = w_quadrant[0] ? ~w_residual : w_residual;
      w_entry.x        = X_INIT;
      w_entry.y        = '0;
      w_entry.quadrant = w_quadrant;
    end else if (in_x[BIT_WIDTH-1]) begin
      // Rotate by pi so x >= 0; the back end undoes it via the fold tag.
      w_entry.x    = sat_negate(in_x);
      w_entry.y    = sat_negate(in_y);
      w_entry.fold = 1'b1;
    end else begin
      w_entry.x = in_x;
      w_entry.y = in_y;
    end
  end

  cordic_skid_fifo #(
    .T (cordic_entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (in_valid),
    .i_din   (w_entry),
    .o_ready (in_ready),
    .i_pop   (start),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign out_target_angle  = w_head.target;
  assign out_current_angle = '0;
  assign out_x             = w_head.x;
  assign out_y             = w_head.y;
  assign out_mode          = w_head.mode;
  assign out_done          = (w_count != 2'd0);
  assign out_quadrant      = w_head.quadrant;
  assign out_fold          = w_head.fold;

endmodule

// File: tb/tb_cordic_input_stage.sv
// -----------------------------------------------------------------------------
// tb_cordic_input_stage
//   Self-checking bench for cordic_input_stage (BIT_WIDTH = 16). Inputs are
//   driven on the falling edge, outputs sampled on the falling edge.
//   Honours CORDIC_GAIN_COMP_EN for the expected rotation x.
// -----------------------------------------------------------------------------
module tb_cordic_input_stage;

  localparam int BW = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [BW-1:0] EXP_XI = 16'sd19898;
`else
  localparam logic signed [BW-1:0] EXP_XI = 16'sd32767;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_mode;
  logic        [BW+1:0] in_angle;
  logic signed [BW-1:0] in_x;
  logic signed [BW-1:0] in_y;
  logic        [BW-1:0] out_target_angle;
  logic signed [BW:0]   out_current_angle;
  logic signed [BW-1:0] out_x;
  logic signed [BW-1:0] out_y;
  logic                 out_mode;
  logic                 out_done;
  logic        [1:0]    out_quadrant;
  logic                 out_fold;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string                name;
    logic                 mode;
    logic        [BW+1:0] angle;
    logic signed [BW-1:0] x;
    logic signed [BW-1:0] y;
    logic        [BW-1:0] e_target;
    logic signed [BW-1:0] e_x;
    logic signed [BW-1:0] e_y;
    logic        [1:0]    e_quad;
    logic                 e_fold;
  } vec_t;

  cordic_input_stage #(.BIT_WIDTH(BW)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_mode           (in_mode),
    .in_angle          (in_angle),
    .in_x              (in_x),
    .in_y              (in_y),
    .out_target_angle  (out_target_angle),
    .out_current_angle (out_current_angle),
    .out_x             (out_x),
    .out_y             (out_y),
    .out_mode          (out_mode),
    .out_done          (out_done),
    .out_quadrant      (out_quadrant),
    .out_fold          (out_fold)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_mode  = v.mode;
    in_angle = v.angle;
    in_x     = v.x;
    in_y     = v.y;
  endtask

  task automatic check_head(input string tag, input vec_t v);
    check({tag, ".done"},   32'(out_done), 32'd1);
    check({tag, ".target"}, 32'(out_target_angle), 32'(v.e_target));
    check({tag, ".x"},      32'(out_x), 32'(v.e_x));
    check({tag, ".y"},      32'(out_y), 32'(v.e_y));
    check({tag, ".mode"},   32'(out_mode), 32'(v.mode));
    check({tag, ".quad"},   32'(out_quadrant), 32'(v.e_quad));
    check({tag, ".fold"},   32'(out_fold), 32'(v.e_fold));
    check({tag, ".cur"},    32'(out_current_angle), 32'd0);
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".done"},  32'(out_done), 32'd0);
    check({tag, ".ready"}, 32'(in_ready), 32'd1);
    check({tag, ".head"},  {out_target_angle, out_x}, 32'd0);
    check({tag, ".tag"},   {out_y, 12'd0, out_mode, out_quadrant, out_fold}, 32'd0);
  endtask

  vec_t vecs [9];
  vec_t va, vb, vc;

  initial begin
    // Rotation: {name, mode, angle, x, y, target, x, y, quadrant, fold}
    vecs[0] = '{"rot_q0",     1'b0, 18'h01234, 16'sd0,      16'sd0,      16'h1234, EXP_XI,      16'sd0,      2'd0, 1'b0};
    vecs[1] = '{"rot_q1",     1'b0, 18'h11234, 16'sd0,      16'sd0,      16'hEDCB, EXP_XI,      16'sd0,      2'd1, 1'b0};
    vecs[2] = '{"rot_q2",     1'b0, 18'h2ABCD, 16'sd5,      16'sd9,      16'hABCD, EXP_XI,      16'sd0,      2'd2, 1'b0};
    vecs[3] = '{"rot_q3_max", 1'b0, 18'h3FFFF, 16'sd0,      16'sd0,      16'h0000, EXP_XI,      16'sd0,      2'd3, 1'b0};
    // Vectoring: angle is ignored, so feed a non-zero one.
    vecs[4] = '{"vec_neg",    1'b1, 18'h3FFFF, -16'sd100,   16'sd50,     16'h0000, 16'sd100,    -16'sd50,    2'd0, 1'b1};
    vecs[5] = '{"vec_min_x",  1'b1, 18'h00000, -16'sd32768, 16'sd7,      16'h0000, 16'sd32767,  -16'sd7,     2'd0, 1'b1};
    vecs[6] = '{"vec_pos",    1'b1, 18'h12345, 16'sd100,    -16'sd20,    16'h0000, 16'sd100,    -16'sd20,    2'd0, 1'b0};
    vecs[7] = '{"vec_zero_x", 1'b1, 18'h00000, 16'sd0,      -16'sd32768, 16'h0000, 16'sd0,      -16'sd32768, 2'd0, 1'b0};
    vecs[8] = '{"vec_min_y",  1'b1, 18'h00000, -16'sd1,     -16'sd32768, 16'h0000, 16'sd1,      16'sd32767,  2'd0, 1'b1};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
    in_angle = '0; in_x = '0; in_y = '0;
    #12;
    check_empty("reset_state");
    @(negedge clk);
    reset = 1'b0;
    step();
    check_empty("after_release");

    // Single-request latency with start held high: shown after the push edge,
    // popped on the following edge.
    for (int i = 0; i < 9; i++) begin
      start = 1'b1;
      drive(vecs[i]);
      step();
      in_valid = 1'b0;
      check_head(vecs[i].name, vecs[i]);
      check({vecs[i].name, ".ready"}, 32'(in_ready), 32'd1);
      step();
      check({vecs[i].name, ".popped"}, 32'(out_done), 32'd0);
      start = 1'b0;
    end

    // Back-to-back with start low: fills at two, third waits for one pop.
    va = vecs[0]; vb = vecs[4]; vc = vecs[2];
    drive(va);
    step();
    check("fill1.ready", 32'(in_ready), 32'd1);
    drive(vb);
    step();
    check("fill2.ready", 32'(in_ready), 32'd0);
    check_head("fill2.head", va);
    drive(vc);
    step();
    check("full_hold.ready", 32'(in_ready), 32'd0);
    check_head("full_hold.head", va);
    start = 1'b1;
    step();
    start = 1'b0;
    check("after_pop.ready", 32'(in_ready), 32'd1);
    check_head("after_pop.head", vb);
    step();
    in_valid = 1'b0;
    check("third_in.ready", 32'(in_ready), 32'd0);
    check_head("third_in.head", vb);
    start = 1'b1;
    step();
    check_head("order.c", vc);
    step();
    start = 1'b0;
    check_empty("drained");

    // Count 1 with push and pop on the same edge.
    drive(vecs[1]);
    step();
    drive(vecs[6]);
    start = 1'b1;
    step();
    in_valid = 1'b0;
    start = 1'b0;
    check_head("swap.head", vecs[6]);
    check("swap.ready", 32'(in_ready), 32'd1);
    step();
    check_head("swap.count1", vecs[6]);
    start = 1'b1;
    step();
    start = 1'b0;
    check_empty("swap.drained");

    // Asynchronous reset with two entries queued.
    drive(vecs[3]);
    step();
    drive(vecs[5]);
    step();
    in_valid = 1'b0;
    check("prereset.ready", 32'(in_ready), 32'd0);
    #1 reset = 1'b1;
    #1 check_empty("async_reset");
    @(negedge clk);
    reset = 1'b0;
    step();
    check_empty("post_reset");
    start = 1'b1;
    step();
    start = 1'b0;
    check_empty("post_reset_start");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
